ifu_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the single-cycle RV32 execute core.
//  - Takes a fetch PC from the core over a valid/ready handshake.
//  - Reads one 32-bit word over an AXI4-Lite-style read channel (AR/R).
//  - Returns instruction + PC + fault flag to the core over a valid/ready handshake.
//  - Supports flush (redirect) and keeps a saturating fetch-stall counter.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_sat_counter.sv | 24 ++
 rtl/ifu_fetch.sv | 164 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ifu_sat_counter.sv
// Saturating up-counter used to count fetch stall cycles.
module ifu_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_r;

  // count up on inc, sticking at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r <= '0;
    end else if (inc && (value_r != {CNT_W{1'b1}})) begin
      value_r <= value_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign value = value_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC handshake in, one AXI4-Lite-style read per PC,
// instruction/fault handshake out, with flush-and-drain redirect support.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              flush,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic [CNT_W-1:0]  stall_cnt
);

  ifu_state_t        state_r, state_s;
  logic [ADDR_W-1:0] req_pc_r;
  logic              drop_r, drop_s;
  logic [DATA_W-1:0] inst_r;
  logic [ADDR_W-1:0] inst_pc_r;
  logic              inst_fault_r;
  logic              pc_ready_s, inst_valid_s, load_pc_s, cap_mis_s, cap_mem_s;
  logic              pc_mis_s, stall_s;

  assign pc_mis_s = is_misaligned(pc[1:0]);

  // next state, handshake readiness and capture strobes
  always_comb begin
    state_s      = state_r;
    pc_ready_s   = 1'b0;
    inst_valid_s = 1'b0;
    load_pc_s    = 1'b0;
    cap_mis_s    = 1'b0;
    cap_mem_s    = 1'b0;
    case (state_r)
      IDLE: begin
        pc_ready_s = 1'b1;
        if (pc_valid) begin
          load_pc_s = 1'b1;
          cap_mis_s = pc_mis_s;
          state_s   = pc_mis_s ? HOLD : ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        // a flush coinciding with arready must still drain the response
        if (mem_arready) begin
          state_s = (drop_r || flush) ? DRAIN : DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_s = IDLE;
          end else begin
            cap_mem_s = 1'b1;
            state_s   = HOLD;
          end
        end else if (flush) begin
          state_s = DRAIN;
        end else begin
          state_s = DATA;
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        inst_valid_s = !flush;
        if (flush) begin
          state_s = IDLE;
        end else if (inst_ready) begin
          pc_ready_s = 1'b1;
          if (pc_valid) begin
            load_pc_s = 1'b1;
            cap_mis_s = pc_mis_s;
            state_s   = pc_mis_s ? HOLD : ADDR;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign drop_s  = (state_r == ADDR) && !mem_arready && (drop_r || flush);
  assign stall_s = (state_r == ADDR) || (state_r == DATA) || (state_r == DRAIN);

  // state, request address and pending-drop registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      req_pc_r <= '0;
      drop_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      drop_r  <= drop_s;
      if (load_pc_s) begin
        req_pc_r <= pc;
      end
    end
  end

  // instruction payload register, loaded from memory or from a misaligned pc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_r       <= '0;
      inst_pc_r    <= '0;
      inst_fault_r <= 1'b0;
    end else if (cap_mem_s) begin
      inst_r       <= (mem_rresp == RESP_OKAY) ? mem_rdata : '0;
      inst_fault_r <= (mem_rresp != RESP_OKAY);
      inst_pc_r    <= req_pc_r;
    end else if (cap_mis_s) begin
      inst_r       <= '0;
      inst_fault_r <= 1'b1;
      inst_pc_r    <= pc;
    end
  end

  ifu_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_s),
    .value (stall_cnt)
  );

  assign pc_ready    = pc_ready_s;
  assign inst_valid  = inst_valid_s;
  assign inst        = inst_r;
  assign inst_pc     = inst_pc_r;
  assign inst_fault  = inst_fault_r;
  assign mem_arvalid = (state_r == ADDR);
  assign mem_araddr  = req_pc_r;
  assign mem_rready  = (state_r == DATA) || (state_r == DRAIN);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic
// against a transaction-level model and a latency-programmable memory slave.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_valid, pc_ready, inst_valid, inst_ready, inst_fault, flush;
  logic [31:0] pc, inst, inst_pc;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata, stall_cnt;
  logic [1:0]  mem_rresp;

  // second instance with a tiny counter to exercise saturation
  logic        s_pc_valid, s_pc_ready, s_inst_valid, s_inst_ready, s_inst_fault, s_flush;
  logic [31:0] s_pc, s_inst, s_inst_pc, s_araddr, s_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_rresp, s_cnt;

  int checks = 0;
  int errors = 0;

  // slave knobs and bookkeeping
  int          ar_delay = 0, r_delay = 0, cur_da = 0, cur_dr = 0, ar_wait = 0, r_wait = 0;
  bit          rand_dly = 1'b0, chk_ar = 1'b0, ar_active = 1'b0, r_pend = 1'b0;
  bit          arvalid_prev = 1'b0, rready_prev = 1'b0;
  logic [31:0] r_addr, ar_addr_prev, stall_acc;
  logic [31:0] ar_q[$];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .flush(flush), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_araddr(mem_araddr), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .stall_cnt(stall_cnt)
  );

  ifu_fetch #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .pc_valid(s_pc_valid), .pc_ready(s_pc_ready), .pc(s_pc),
    .inst_valid(s_inst_valid), .inst_ready(s_inst_ready), .inst(s_inst), .inst_pc(s_inst_pc),
    .inst_fault(s_inst_fault), .flush(s_flush), .mem_arvalid(s_arvalid),
    .mem_arready(s_arready), .mem_araddr(s_araddr), .mem_rvalid(s_rvalid),
    .mem_rready(s_rready), .mem_rdata(s_rdata), .mem_rresp(s_rresp), .stall_cnt(s_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    if (a == 32'h8000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    return (a == 32'h8000_0100) || (a[5:2] == 4'hB);
  endfunction

  // expected {fault, inst, inst_pc} for a fetch of address a
  function automatic logic [64:0] expect_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return {1'b1, 32'h0, a};
    if (mem_err(a)) return {1'b1, 32'h0, a};
    return {1'b0, mem_word(a), a};
  endfunction

  // memory slave: programmable AR/R latency, one response per accepted address
  initial begin
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rresp = 2'b00;
    stall_acc = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; r_pend = 1'b0; ar_active = 1'b0;
        arvalid_prev = 1'b0; rready_prev = 1'b0; stall_acc = 32'h0; ar_q.delete();
      end else begin
        if (mem_rvalid && rready_prev) begin
          mem_rvalid = 1'b0; r_pend = 1'b0;
          stall_acc = stall_acc + 32'(cur_da + cur_dr + 2);
        end
        if (mem_arready && arvalid_prev) begin
          mem_arready = 1'b0; ar_active = 1'b0; r_pend = 1'b1; r_wait = 0;
          r_addr = ar_addr_prev;
          cur_dr = rand_dly ? int'($urandom_range(0, 3)) : r_delay;
          if (chk_ar) begin
            checks++;
            if (ar_q.size() == 0) begin
              errors++; $display("FAIL ar_addr: got unexpected read of %h, required no read", r_addr);
            end else if (ar_q[0] !== r_addr) begin
              errors++; $display("FAIL ar_addr: got %h required %h", r_addr, ar_q[0]);
            end
            if (ar_q.size() != 0) void'(ar_q.pop_front());
          end
        end
        if (r_pend) begin
          checks++;
          if (mem_arvalid !== 1'b0) begin
            errors++; $display("FAIL one_outstanding: got arvalid=%b required 0", mem_arvalid);
          end
        end
        if (mem_arvalid && !mem_arready && !r_pend) begin
          if (!ar_active) begin
            ar_active = 1'b1; ar_wait = 0;
            cur_da = rand_dly ? int'($urandom_range(0, 3)) : ar_delay;
          end
          if (ar_wait >= cur_da) mem_arready = 1'b1;
          else ar_wait++;
        end
        if (r_pend && !mem_rvalid) begin
          if (r_wait >= cur_dr) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(r_addr);
            mem_rresp  = mem_err(r_addr) ? 2'b10 : 2'b00;
          end else begin
            r_wait++;
          end
        end
        arvalid_prev = mem_arvalid; rready_prev = mem_rready; ar_addr_prev = mem_araddr;
      end
    end
  end

  task automatic issue_pc(input logic [31:0] a);
    @(negedge clk);
    pc = a; pc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (pc_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic wait_inst(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (inst_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    @(negedge clk); inst_ready = 1'b1;
    @(negedge clk); inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_valid = 1'b0; pc = 32'h0; inst_ready = 1'b0; flush = 1'b0;
    s_pc_valid = 1'b0; s_pc = 32'h0; s_inst_ready = 1'b0; s_flush = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
    @(negedge clk); #1;
    checks++;
    if ({inst, inst_pc, mem_araddr, stall_cnt} !== 128'h0 || {inst_fault, inst_valid, mem_arvalid, mem_rready, pc_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_state: got inst=%h pc=%h araddr=%h cnt=%h flags=%b required zeros, flags 00001",
                         inst, inst_pc, mem_araddr, stall_cnt, {inst_fault, inst_valid, mem_arvalid, mem_rready, pc_ready});
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (pc_ready !== 1'b1 || inst_valid !== 1'b0 || stall_cnt !== 32'h0) begin
      errors++; $display("FAIL post_reset: got pc_ready=%b inst_valid=%b cnt=%h required 1 0 0", pc_ready, inst_valid, stall_cnt);
    end
  endtask

  task automatic test_aligned();
    ar_delay = 0; r_delay = 0;
    issue_pc(RESET_PC); #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== RESET_PC) begin
      errors++; $display("FAIL aligned_ar: got arvalid=%b araddr=%h required 1 %h", mem_arvalid, mem_araddr, RESET_PC);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b0 || mem_rready !== 1'b1) begin
      errors++; $display("FAIL aligned_n2: got inst_valid=%b rready=%b required 0 1", inst_valid, mem_rready);
    end
    @(negedge clk); #1;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== RESET_PC || inst_fault !== 1'b0) begin
      errors++; $display("FAIL aligned_n3: got v=%b inst=%h pc=%h f=%b required 1 00000413 %h 0", inst_valid, inst, inst_pc, inst_fault, RESET_PC);
    end
    consume(); #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL aligned_done: got inst_valid=%b pc_ready=%b required 0 1", inst_valid, pc_ready);
    end
  endtask

  task automatic test_misaligned();
    issue_pc(32'h8000_0002); #1;
    checks++;
    if (mem_arvalid !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0002) begin
      errors++; $display("FAIL misaligned: got ar=%b v=%b inst=%h f=%b pc=%h required 0 1 0 1 80000002",
                         mem_arvalid, inst_valid, inst, inst_fault, inst_pc);
    end
    consume();
  endtask

  task automatic test_bus_error();
    logic [31:0] s0;
    bit got;
    s0 = stall_cnt; ar_delay = 1; r_delay = 2;
    issue_pc(32'h8000_0100);
    wait_inst(20, got);
    checks++;
    if (!got || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0100) begin
      errors++; $display("FAIL bus_error: got v=%b inst=%h f=%b pc=%h required 1 0 1 80000100", got, inst, inst_fault, inst_pc);
    end
    checks++;
    if (stall_cnt - s0 !== 32'd5) begin
      errors++; $display("FAIL bus_error_stall: got delta %0d required 5", stall_cnt - s0);
    end
    consume();
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_flush_data();
    bit saw, got;
    ar_delay = 0; r_delay = 2; saw = 1'b0;
    issue_pc(32'h8000_0008);
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (inst_valid !== 1'b0 || mem_rready !== 1'b1 || mem_rvalid !== 1'b0) begin
      errors++; $display("FAIL flush_data_in: got v=%b rready=%b rvalid=%b required 0 1 0", inst_valid, mem_rready, mem_rvalid);
    end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if (mem_rready !== 1'b1 || mem_arvalid !== 1'b0 || pc_ready !== 1'b0) begin
      errors++; $display("FAIL flush_drain: got rready=%b ar=%b pc_ready=%b required 1 0 0", mem_rready, mem_arvalid, pc_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      saw = saw | inst_valid;
      if (pc_ready) break;
    end
    checks++;
    if (saw !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL flush_data_idle: got saw_valid=%b pc_ready=%b required 0 1", saw, pc_ready);
    end
    r_delay = 0;
    issue_pc(32'h8000_0010);
    wait_inst(10, got);
    checks++;
    if (!got || inst !== mem_word(32'h8000_0010) || inst_fault !== 1'b0 || inst_pc !== 32'h8000_0010) begin
      errors++; $display("FAIL flush_refetch: got v=%b inst=%h f=%b pc=%h required 1 %h 0 80000010",
                         got, inst, inst_fault, inst_pc, mem_word(32'h8000_0010));
    end
    consume();
  endtask

  task automatic test_flush_addr();
    bit saw;
    ar_delay = 3; r_delay = 1; saw = 1'b0;
    issue_pc(32'h8000_0020);
    flush = 1'b1; #1;
    checks++;
    if (mem_arvalid !== 1'b1) begin
      errors++; $display("FAIL flush_addr_in: got arvalid=%b required 1", mem_arvalid);
    end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0020) begin
      errors++; $display("FAIL flush_addr_hold: got ar=%b addr=%h required 1 80000020", mem_arvalid, mem_araddr);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      saw = saw | inst_valid;
      if (pc_ready) break;
    end
    checks++;
    if (saw !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL flush_addr_idle: got saw_valid=%b pc_ready=%b required 0 1", saw, pc_ready);
    end
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit got;
    issue_pc(32'h8000_0030);
    wait_inst(10, got);
    held = mem_word(32'h8000_0030);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (inst_valid !== 1'b1 || inst !== held || inst_pc !== 32'h8000_0030) begin
        errors++; $display("FAIL backpressure_hold: got v=%b inst=%h pc=%h required 1 %h 80000030", inst_valid, inst, inst_pc, held);
      end
    end
    @(negedge clk); inst_ready = 1'b1; pc_valid = 1'b1; pc = 32'h8000_0040; #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_pc_ready: got %b required 1", pc_ready);
    end
    @(negedge clk); inst_ready = 1'b0; pc_valid = 1'b0; #1;
    checks++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0040 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_back_ar: got ar=%b addr=%h v=%b required 1 80000040 0", mem_arvalid, mem_araddr, inst_valid);
    end
    wait_inst(10, got);
    checks++;
    if (!got || inst !== mem_word(32'h8000_0040)) begin
      errors++; $display("FAIL back_to_back_inst: got v=%b inst=%h required 1 %h", got, inst, mem_word(32'h8000_0040));
    end
    @(negedge clk); flush = 1'b1; inst_ready = 1'b1; pc_valid = 1'b1; pc = 32'h8000_0044; #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b0) begin
      errors++; $display("FAIL flush_hold: got v=%b pc_ready=%b required 0 0", inst_valid, pc_ready);
    end
    @(negedge clk); flush = 1'b0; inst_ready = 1'b0; pc_valid = 1'b0; #1;
    checks++;
    if (inst_valid !== 1'b0 || pc_ready !== 1'b1 || mem_arvalid !== 1'b0) begin
      errors++; $display("FAIL flush_hold_idle: got v=%b pc_ready=%b ar=%b required 0 1 0", inst_valid, pc_ready, mem_arvalid);
    end
  endtask

  task automatic test_async_reset();
    ar_delay = 1000;
    issue_pc(32'h8000_0050); #1;
    checks++;
    if (mem_arvalid !== 1'b1) begin
      errors++; $display("FAIL reset_pre: got arvalid=%b required 1", mem_arvalid);
    end
    #2 reset = 1'b1; #1;
    checks++;
    if ({inst, inst_pc, mem_araddr, stall_cnt} !== 128'h0 || {inst_fault, inst_valid, mem_arvalid, mem_rready, pc_ready} !== 5'b00001) begin
      errors++; $display("FAIL async_reset: got inst=%h pc=%h araddr=%h cnt=%h flags=%b required zeros, flags 00001",
                         inst, inst_pc, mem_araddr, stall_cnt, {inst_fault, inst_valid, mem_arvalid, mem_rready, pc_ready});
    end
    @(negedge clk);
    @(negedge clk); reset = 1'b0; ar_delay = 0;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    @(negedge clk); s_pc = RESET_PC; s_pc_valid = 1'b1;
    @(negedge clk); s_pc_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      want = (k < 3) ? 2'(k) : 2'b11;
      checks++;
      if (s_cnt !== want) begin
        errors++; $display("FAIL saturation[%0d]: got %0d required %0d", k, s_cnt, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [64:0] exp_q[$];
    logic [64:0] e;
    logic [31:0] a;
    bit have_req;
    have_req = 1'b0; rand_dly = 1'b1; chk_ar = 1'b1;
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(negedge clk);
      if (cyc < 600) begin
        if (!have_req && $urandom_range(0, 2) != 0) begin
          have_req = 1'b1;
          a = RESET_PC + ($urandom_range(0, 255) << 2);
          if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
          pc = a;
        end
        pc_valid   = have_req;
        inst_ready = ($urandom_range(0, 3) != 0);
      end else begin
        pc_valid = 1'b0; inst_ready = 1'b1;
      end
      #1;
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got inst %h at pc %h required no instruction", inst, inst_pc);
        end else begin
          e = exp_q.pop_front();
          if ({inst_fault, inst, inst_pc} !== e) begin
            errors++; $display("FAIL rand_inst: got f=%b inst=%h pc=%h required f=%b inst=%h pc=%h",
                               inst_fault, inst, inst_pc, e[64], e[63:32], e[31:0]);
          end
        end
      end
      if (pc_valid && pc_ready) begin
        exp_q.push_back(expect_of(pc));
        if (pc[1:0] == 2'b00) ar_q.push_back(pc);
        have_req = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0 || ar_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d insts and %0d reads outstanding required 0 0", exp_q.size(), ar_q.size());
    end
    checks++;
    if (stall_cnt !== stall_acc) begin
      errors++; $display("FAIL rand_stall: got %0d required %0d", stall_cnt, stall_acc);
    end
    rand_dly = 1'b0; chk_ar = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_bus_error();
    test_flush_data();
    test_flush_addr();
    test_backpressure();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard bound so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
